// File: rtl/mod3_pkg.sv
// Shared constants and the mod-3 reduction used by the serial residue engine.
package mod3_pkg;

   localparam int OPERAND_W = 32;
   localparam int NIBBLE_W  = 4;
   localparam int NIBBLES   = 8;
   localparam int CNT_W     = 8;

   // Reduce a 5-bit value (0..31) mod 3 without a divider.
   // Bit weights mod 3 alternate 1,2,1,2,1, so a weighted popcount gives
   // 0..7. One more pass gives 0..4, and a single conditional subtract ends it.
   function automatic logic [1:0] mod3_reduce(input logic [4:0] v);
      logic [2:0] t;
      logic [2:0] u;
      t = {2'b00, v[0]} + {2'b00, v[2]} + {2'b00, v[4]}
        + {1'b0, v[1], 1'b0} + {1'b0, v[3], 1'b0};
      u = {2'b00, t[0]} + {2'b00, t[2]} + {1'b0, t[1], 1'b0};
      return (u >= 3'd3) ? 2'(u - 3'd3) : u[1:0];
   endfunction

endpackage

// File: rtl/mod3_nibble_fold.sv
// Combinational fold of one nibble into a running mod-3 residue.
// Works MSB-first because 16 = 1 (mod 3), so shifting by a nibble keeps the residue.
module mod3_nibble_fold
   import mod3_pkg::*;
(
   input  logic [1:0]          i_res,
   input  logic [NIBBLE_W-1:0] i_nib,
   output logic [1:0]          o_res
);

   logic [4:0] w_sum;

   // Sum is at most 2 + 15 = 17, so 5 bits are enough
   assign w_sum = {3'b000, i_res} + {1'b0, i_nib};
   assign o_res = mod3_reduce(w_sum);

endmodule

// File: rtl/source32_mod3.sv
// Serial residue-mod-3 engine: folds one nibble of x[31:0] per enabled
// clock, MSB nibble first, and flags done after eight nibbles.
module source32_mod3
   import mod3_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      x,
   input  logic             e,
   output logic [1:0]       s,
   output logic             f,
   output logic [CNT_W-1:0] i
);

   logic [1:0]           r_s;
   logic [CNT_W-1:0]     r_i;
   logic                 r_f;
   logic [OPERAND_W-1:0] w_op;
   logic [2:0]           w_sel;
   logic [NIBBLE_W-1:0]  w_nib;
   logic [1:0]           w_fold;
   logic                 w_busy;
   logic                 w_unused;

   // Upper operand half is ignored by design
   assign w_op     = x[OPERAND_W-1:0];
   assign w_unused = ^x[63:OPERAND_W];

   // Nibble mux: count 0 selects bits 31:28, count 7 selects bits 3:0
   assign w_sel = 3'(NIBBLES - 1) - r_i[2:0];
   assign w_nib = w_op[{w_sel, 2'b00} +: NIBBLE_W];

   assign w_busy = (r_i != CNT_W'(NIBBLES));

   mod3_nibble_fold u_fold (
      .i_res (r_s),
      .i_nib (w_nib),
      .o_res (w_fold)
   );

   // Residue, nibble count and done flag; e low clears, count saturates at 8.
   // Done is its own register (set on the last fold) so it never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s <= 2'd0;
         r_i <= '0;
         r_f <= 1'b0;
      end else if (!e) begin
         r_s <= 2'd0;
         r_i <= '0;
         r_f <= 1'b0;
      end else if (w_busy) begin
         r_s <= w_fold;
         r_i <= r_i + CNT_W'(1);
         r_f <= (r_i == CNT_W'(NIBBLES - 1));
      end
   end

   assign s = r_s;
   assign i = r_i;
   assign f = r_f;

endmodule

// File: tb/tb_source32_mod3.sv
// Scoreboard bench for source32_mod3: the stimulus side predicts the state
// after every edge from x's leading nibbles; a monitor compares at negedge.
module tb_source32_mod3;

   typedef struct {
      logic [1:0] s;
      logic [7:0] i;
      logic       f;
      string      tag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [63:0] x;
   logic        e;
   logic [1:0]  s;
   logic        f;
   logic [7:0]  i;

   exp_t q[$];
   int   n_cmp;
   int   n_bad;

   // reference model state
   int   m_i;
   int   m_s;
   bit   m_f;

   source32_mod3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .e     (e),
      .s     (s),
      .f     (f),
      .i     (i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // after k folds, residue is the top 4k bits of x[31:0] taken as a number, mod 3
   function automatic int prefix_mod3(input logic [63:0] xv, input int k);
      int unsigned v;
      v = xv[31:0];
      if (k == 0) return 0;
      return int'((v >> (32 - 4 * k)) % 3);
   endfunction

   task automatic cyc(input logic ev, input logic [63:0] xv, input bit pulse_rst, input string tag);
      exp_t ex;
      e = ev;
      x = xv;
      @(posedge clk);
      if (!rst_n || !ev) begin
         m_i = 0; m_s = 0; m_f = 0;
      end else if (m_i < 8) begin
         m_i = m_i + 1;
         m_s = prefix_mod3(xv, m_i);
         m_f = (m_i == 8);
      end
      if (pulse_rst) begin
         #2;
         rst_n = 1'b0;
         m_i = 0; m_s = 0; m_f = 0;
      end
      ex.s = m_s[1:0]; ex.i = m_i[7:0]; ex.f = m_f; ex.tag = tag;
      q.push_back(ex);
      @(negedge clk);
      #1;
      if (pulse_rst) rst_n = 1'b1;
   endtask

   task automatic run(input logic [63:0] xv, input int n_en, input string tag);
      cyc(1'b0, xv, 1'b0, {tag, "_clr"});
      for (int k = 0; k < n_en; k++) cyc(1'b1, xv, 1'b0, tag);
   endtask

   // monitor: compare DUT against the oldest prediction each negedge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t ex;
         ex = q.pop_front();
         n_cmp++;
         if (s !== ex.s || i !== ex.i || f !== ex.f) begin
            n_bad++;
            $display("FAIL %s: got s=%0d i=%0d f=%0d, want s=%0d i=%0d f=%0d",
                     ex.tag, s, i, f, ex.s, ex.i, ex.f);
         end
         n_cmp++;
         if (s === 2'd3) begin
            n_bad++;
            $display("FAIL %s_range: got s=%0d, want s in 0..2", ex.tag, s);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, want finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] rx;
      int          ne;
      n_cmp = 0; n_bad = 0;
      m_i = 0; m_s = 0; m_f = 0;
      rst_n = 1'b0; e = 1'b0; x = '0;
      // reset state, with e high to show reset dominates
      cyc(1'b1, 64'd117, 1'b0, "reset");
      cyc(1'b1, 64'd117, 1'b0, "reset");
      rst_n = 1'b1;

      run(64'd117,        13, "x117");
      run(64'd425117,     12, "x425117");
      run(64'd827425117,  10, "x827425117");
      run(64'd4294967295, 9,  "xffffffff");
      run(64'hFFFF_FFFF_0000_0075, 9, "upper_ignored");

      // abort after 4 folds, then full restart
      run(64'd827425117, 4, "abort");
      cyc(1'b0, 64'd425117, 1'b0, "abort_clr");
      for (int k = 0; k < 10; k++) cyc(1'b1, 64'd425117, 1'b0, "restart");

      // async reset between edges, mid-run
      cyc(1'b0, 64'd827425117, 1'b0, "rst_clr");
      for (int k = 0; k < 3; k++) cyc(1'b1, 64'd827425117, 1'b0, "pre_rst");
      cyc(1'b1, 64'd827425117, 1'b1, "async_rst");
      run(64'd827425117, 9, "post_rst");

      // randomized runs, some aborted early
      for (int r = 0; r < 25; r++) begin
         rx = {$urandom(), $urandom()};
         ne = (r % 5 == 4) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 12));
         run(rx, ne, "rand");
      end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
